kmeans_iteration_controller: RTL and testbench

KMEANS_ITERATION_CONTROLLER -- requirements
Module: kmeans_iteration_controller

---
 rtl/kmeans_iteration_controller.sv | 171 +++++++++++++++++
 tb/tb_kmeans_iteration_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_iteration_controller.sv
// Sequences k-means iterations: clear -> classify -> per-centroid means -> convergence eval, until converged or max_iter.
// Optional KMEANS_ITER_TIMEOUT_EN adds an 8-bit wait watchdog that raises error and forces DONE.
module kmeans_iteration_controller #(
  parameter int centroid_num = 8,
  parameter int iter_width   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [iter_width-1:0] max_iter,
  output logic                  classify_start,
  input  logic                  classify_done,
  output logic                  mean_req,
  input  logic                  mean_valid,
  output logic [2:0]            cent_num,
  output logic                  convergence_reg_en,
  output logic                  convergence_regs_reset_n,
  input  logic                  has_converged,
  input  logic                  converge_res_available,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  error,
  output logic [iter_width-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    CLASSIFY = 3'd2,
    MEANS    = 3'd3,
    EVAL     = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [2:0] last_cent = 3'(centroid_num - 1);

  state_t                state;
  logic [iter_width-1:0] iter_limit;
  logic [iter_width-1:0] iter_next;
  logic                  timeout;

  assign iter_next = (iter_count == '1) ? iter_count : iter_count + 1'b1;

  // The convergence block must capture the mean in the same cycle it is presented.
  assign convergence_reg_en = (state == MEANS) && mean_valid && !rst;

`ifdef KMEANS_ITER_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       waiting;
  logic       handshake;
  logic       error_q;

  assign waiting   = (state == CLASSIFY) || (state == MEANS) || (state == EVAL);
  assign handshake = ((state == CLASSIFY) && classify_done) ||
                     ((state == MEANS) && mean_valid) ||
                     ((state == EVAL) && converge_res_available);
  assign timeout   = waiting && !handshake && (wd_cnt == 8'd254);
  assign error     = error_q;

  always_ff @(posedge clk) begin
    if (rst || !waiting || handshake) begin
      wd_cnt <= 8'd0;
    end else begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      cent_num                 <= 3'd0;
      iter_count               <= '0;
      iter_limit               <= '0;
      busy                     <= 1'b0;
      done                     <= 1'b0;
      converged                <= 1'b0;
      classify_start           <= 1'b0;
      mean_req                 <= 1'b0;
      convergence_regs_reset_n <= 1'b0;
`ifdef KMEANS_ITER_TIMEOUT_EN
      error_q                  <= 1'b0;
`endif
    end else if (timeout) begin
      state                    <= DONE;
      busy                     <= 1'b0;
      done                     <= 1'b1;
      converged                <= 1'b0;
      classify_start           <= 1'b0;
      mean_req                 <= 1'b0;
      convergence_regs_reset_n <= 1'b1;
`ifdef KMEANS_ITER_TIMEOUT_EN
      error_q                  <= 1'b1;
`endif
    end else begin
      classify_start <= 1'b0;
      case (state)
        IDLE: begin
          convergence_regs_reset_n <= 1'b0;
          if (start) begin
            iter_limit <= max_iter;
            iter_count <= '0;
            cent_num   <= 3'd0;
            done       <= 1'b0;
            converged  <= 1'b0;
`ifdef KMEANS_ITER_TIMEOUT_EN
            error_q    <= 1'b0;
`endif
            if (max_iter == '0) begin
              state                    <= DONE;
              done                     <= 1'b1;
              convergence_regs_reset_n <= 1'b1;
            end else begin
              state <= CLEAR;
              busy  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state                    <= CLASSIFY;
          classify_start           <= 1'b1;
          convergence_regs_reset_n <= 1'b1;
        end
        CLASSIFY: begin
          if (classify_done) begin
            state    <= MEANS;
            mean_req <= 1'b1;
          end
        end
        MEANS: begin
          // cent_num parks on the last centroid for the convergence check during EVAL
          if (mean_valid) begin
            if (cent_num == last_cent) begin
              state    <= EVAL;
              mean_req <= 1'b0;
            end else begin
              cent_num <= cent_num + 3'd1;
            end
          end
        end
        EVAL: begin
          if (converge_res_available) begin
            iter_count <= iter_next;
            if (has_converged || (iter_next == iter_limit)) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              converged <= has_converged;
            end else begin
              state                    <= CLEAR;
              cent_num                 <= 3'd0;
              convergence_regs_reset_n <= 1'b0;
            end
          end
        end
        DONE: begin
          state                    <= IDLE;
          convergence_regs_reset_n <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_iteration_controller.sv
// Bench for kmeans_iteration_controller: table vectors, randomized jobs against an outcome model, reset/watchdog sequences.
module tb_kmeans_iteration_controller;

  localparam int CN = 8;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] max_iter;
  logic       classify_start, classify_done;
  logic       mean_req, mean_valid;
  logic [2:0] cent_num;
  logic       convergence_reg_en, convergence_regs_reset_n;
  logic       has_converged, converge_res_available;
  logic       busy, done, converged, error;
  logic [7:0] iter_count;

  int total = 0;
  int bad   = 0;

  kmeans_iteration_controller #(.centroid_num(CN), .iter_width(8)) dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter),
    .classify_start(classify_start), .classify_done(classify_done),
    .mean_req(mean_req), .mean_valid(mean_valid), .cent_num(cent_num),
    .convergence_reg_en(convergence_reg_en),
    .convergence_regs_reset_n(convergence_regs_reset_n),
    .has_converged(has_converged), .converge_res_available(converge_res_available),
    .busy(busy), .done(done), .converged(converged), .error(error),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected number of iterations from the algorithm's rules.
  function automatic int ref_iters(input int mi, input int conv_at);
    if (mi == 0) return 0;
    if (conv_at >= 1 && conv_at <= mi) return conv_at;
    return mi;
  endfunction

  task automatic run_job(input int mi, input int conv_at, input int cls_dly, input int mv_pct,
                         input int eval_dly, input bit noise, input int exp_iters,
                         input bit exp_conv, input string tag);
    int  n_cls = 0, n_clr = 0, n_en = 0, perr = 0, idx = 0, iters_seen = 0;
    int  cnt_c = 0, cnt_e = 0, cycles = 0;
    bit  cls_pend = 0, ev_pend = 0, ev_next = 0, prev_cs = 0;
    @(negedge clk);
    start = 1'b1; max_iter = 8'(mi);
    @(negedge clk);
    start = 1'b0; max_iter = 8'($urandom);
    chk({tag, " conv_cleared"}, converged, 0);
    if (mi == 0) chk({tag, " zero_iter_done"}, done, 1);
    else begin
      chk({tag, " done_cleared"}, done, 0);
      chk({tag, " busy_on_start"}, busy, 1);
    end
    while (!done && cycles < 5000) begin
      if (busy && !convergence_regs_reset_n) begin
        n_clr++;
        if (cent_num != 3'd0) perr++;
      end
      if (classify_start) begin
        n_cls++;
        if (prev_cs) perr++;
        cls_pend = 1; cnt_c = cls_dly;
      end
      prev_cs = classify_start;
      classify_done = 1'b0;
      if (cls_pend) begin
        if (cnt_c == 0) begin classify_done = 1'b1; cls_pend = 0; end
        else cnt_c--;
      end
      converge_res_available = 1'b0;
      has_converged = noise ? 1'($urandom) : 1'b0;
      if (ev_next) begin ev_pend = 1; cnt_e = eval_dly; ev_next = 0; end
      if (ev_pend) begin
        if (cnt_e == 0) begin
          iters_seen++;
          converge_res_available = 1'b1;
          has_converged = (iters_seen == conv_at);
          ev_pend = 0;
        end else cnt_e--;
      end
      mean_valid = mean_req && ($urandom_range(99, 0) < mv_pct);
      start = noise && busy && ($urandom_range(15, 0) == 0);
      #1;
      if (convergence_reg_en !== mean_valid) perr++;
      if (mean_valid) begin
        if (cent_num != 3'(idx)) perr++;
        n_en++; idx++;
        if (idx == CN) begin idx = 0; ev_next = 1; end
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0; classify_done = 1'b0; mean_valid = 1'b0;
    converge_res_available = 1'b0; has_converged = 1'b0;
    chk({tag, " finished_in_budget"}, cycles < 5000, 1);
    chk({tag, " done"}, done, 1);
    chk({tag, " converged"}, converged, exp_conv);
    chk({tag, " iter_count"}, iter_count, exp_iters);
    chk({tag, " classify_pulses"}, n_cls, exp_iters);
    chk({tag, " clear_cycles"}, n_clr, exp_iters);
    chk({tag, " reg_en_cycles"}, n_en, CN * exp_iters);
    chk({tag, " protocol_errors"}, perr, 0);
    chk({tag, " error"}, error, 0);
    repeat (3) @(negedge clk);
    chk({tag, " done_held"}, done, 1);
    chk({tag, " iter_held"}, iter_count, exp_iters);
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_clr_n"}, convergence_regs_reset_n, 0);
  endtask

  // Runs a job up to MEANS at the given centroid index with means granted every cycle.
  task automatic advance_to_cent(input logic [2:0] target, input string tag);
    int k = 0;
    @(negedge clk);
    start = 1'b1; max_iter = 8'd4;
    @(negedge clk);
    start = 1'b0;
    while (!(mean_req && cent_num == target) && k < 60) begin
      classify_done = classify_start;
      mean_valid    = mean_req;
      @(negedge clk);
      k++;
    end
    classify_done = 1'b0;
    chk({tag, " reached_target"}, k < 60, 1);
  endtask

  typedef struct {
    int mi; int conv_at; int cls_dly; int mv_pct; int eval_dly; bit noise;
    int exp_iters; bit exp_conv;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4,   1, 3, 100, 0, 1'b0,   1, 1'b1};
    vecs[1] = '{3,   0, 1, 100, 2, 1'b1,   3, 1'b0};
    vecs[2] = '{0,   1, 0, 100, 0, 1'b0,   0, 1'b0};
    vecs[3] = '{5,   3, 0,  50, 1, 1'b1,   3, 1'b1};
    vecs[4] = '{2,   2, 5,  70, 3, 1'b1,   2, 1'b1};
    vecs[5] = '{1,   0, 2, 100, 0, 1'b0,   1, 1'b0};
    vecs[6] = '{255, 0, 0, 100, 0, 1'b0, 255, 1'b0};

    rst = 1'b1; start = 1'b0; max_iter = 8'd0; classify_done = 1'b0; mean_valid = 1'b0;
    has_converged = 1'b0; converge_res_available = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst converged", converged, 0);
    chk("rst error", error, 0);
    chk("rst classify_start", classify_start, 0);
    chk("rst mean_req", mean_req, 0);
    chk("rst reg_en", convergence_reg_en, 0);
    chk("rst clr_n", convergence_regs_reset_n, 0);
    chk("rst cent_num", cent_num, 0);
    chk("rst iter_count", iter_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle clr_n", convergence_regs_reset_n, 0);

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].mi, vecs[i].conv_at, vecs[i].cls_dly, vecs[i].mv_pct, vecs[i].eval_dly,
              vecs[i].noise, vecs[i].exp_iters, vecs[i].exp_conv, $sformatf("vec%0d", i));
    end

    for (int j = 0; j < 12; j++) begin
      int mi, ca, it;
      mi = $urandom_range(6, 0);
      ca = $urandom_range(7, 0);
      it = ref_iters(mi, ca);
      run_job(mi, ca, $urandom_range(4, 0), $urandom_range(100, 30), $urandom_range(3, 0), 1'b1,
              it, (it != 0) && (it == ca), $sformatf("rnd%0d", j));
    end

    advance_to_cent(3'd5, "midrst");
    rst = 1'b1; start = 1'b1; mean_valid = 1'b1; classify_done = 1'b1;
    converge_res_available = 1'b1; has_converged = 1'b1;
    #1;
    chk("midrst reg_en_gated", convergence_reg_en, 0);
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst converged", converged, 0);
    chk("midrst error", error, 0);
    chk("midrst classify_start", classify_start, 0);
    chk("midrst mean_req", mean_req, 0);
    chk("midrst reg_en", convergence_reg_en, 0);
    chk("midrst clr_n", convergence_regs_reset_n, 0);
    chk("midrst cent_num", cent_num, 0);
    chk("midrst iter_count", iter_count, 0);
    rst = 1'b0; start = 1'b0; mean_valid = 1'b0; classify_done = 1'b0;
    converge_res_available = 1'b0; has_converged = 1'b0;
    @(negedge clk);
    chk("midrst stays_idle", busy, 0);

    advance_to_cent(3'd2, "stall");
    mean_valid = 1'b0;
`ifdef KMEANS_ITER_TIMEOUT_EN
    begin
      int n = 0;
      while (!done && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("stall wait_cycles", n, 255);
      chk("stall error", error, 1);
      chk("stall done", done, 1);
      chk("stall converged", converged, 0);
      chk("stall busy", busy, 0);
    end
`else
    repeat (300) @(negedge clk);
    chk("stall busy", busy, 1);
    chk("stall mean_req", mean_req, 1);
    chk("stall cent_num", cent_num, 2);
    chk("stall done", done, 0);
    chk("stall error", error, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
